// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: integer pixel-clock divider, h/v counters,
// and sync/blanking strobes delayed LAT pixel ticks to line up with pixel data.
module vga_timing_gen #(
    parameter int H_DISP  = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_DISP  = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 0,
    parameter int CLK_DIV = 4,
    parameter int LAT     = 1,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    output logic               pix_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               hsync,
    output logic               vsync,
    output logic               video_on,
    output logic               line_start,
    output logic               frame_start,
    output logic [15:0]        frame_count
);
    localparam int H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_DISP);
    localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_DISP);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISP + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISP + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISP + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISP + V_FP + V_SYNC - 1);
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    generate
        if (H_TOTAL > (1 << COORD_W) || V_TOTAL > (1 << COORD_W)) begin : g_bad_coord_w
            $error("vga_timing_gen: H_TOTAL/V_TOTAL do not fit in COORD_W bits");
        end
        if (CLK_DIV < 1 || LAT < 1) begin : g_bad_div_lat
            $error("vga_timing_gen: CLK_DIV and LAT must be >= 1");
        end
    endgenerate

    logic [DIV_W-1:0]   div_q, div_d;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;
    logic [2:0]         strobe_q [LAT];
    logic               line_start_q, frame_start_q;
    logic [15:0]        frame_count_q;
    logic               tick, h_end, v_end;
    logic               hs_act, vs_act, vid;

    // Gated by reset so the pixel enable is low for the whole reset interval, even with CLK_DIV = 1.
    assign tick  = reset & en & (div_q == DIV_LAST);
    assign h_end = (h_q == H_LAST);
    assign v_end = (v_q == V_LAST);

    assign hs_act = (h_q >= HS_FIRST) && (h_q <= HS_LAST);
    assign vs_act = (v_q >= VS_FIRST) && (v_q <= VS_LAST);
    assign vid    = (h_q < H_ACT) && (v_q < V_ACT);

    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (en) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
        if (tick) begin
            h_d = h_end ? '0 : h_q + COORD_W'(1);
            if (h_end) begin
                v_d = v_end ? '0 : v_q + COORD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q         <= '0;
            h_q           <= '0;
            v_q           <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            line_start_q  <= tick & h_end;
            frame_start_q <= tick & h_end & v_end;
            if (tick & h_end & v_end) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

    // Stage 0 captures the decode of the pre-increment position, so the last stage trails pixel_x by LAT ticks.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LAT; i++) begin
                strobe_q[i] <= 3'b000;
            end
        end else if (tick) begin
            strobe_q[0] <= {hs_act, vs_act, vid};
            for (int i = 1; i < LAT; i++) begin
                strobe_q[i] <= strobe_q[i-1];
            end
        end
    end

    assign pix_tick    = tick;
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign hsync       = strobe_q[LAT-1][2] ? HS_ON : ~HS_ON;
    assign vsync       = strobe_q[LAT-1][1] ? VS_ON : ~VS_ON;
    assign video_on    = strobe_q[LAT-1][0];
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator. It is the successor to the fixed 640x480 controller. It derives a pixel-rate enable from the system clock by an integer divider and produces the pixel coordinates and the sync and blanking strobes. Every timing value, the sync polarity and the divider ratio are parameters. A configurable pipeline delays the strobes by LAT pixel ticks so they align with downstream pixel data, such as the frame-buffer read latency. The block feeds the video output stage and the pixel-source logic.

Parameters:
H_DISP, 640, horizontal active pixels
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISP, 480, vertical active lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level (0 = active-low)
CLK_DIV, 4, system clocks per pixel, >= 1
LAT, 1, strobe delay in pixel ticks, >= 1
COORD_W, 10, coordinate width; H_TOTAL and V_TOTAL must each be <= 2^COORD_W (elaboration check)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (0 = reset)
en  in  1  run enable; while low, all counters and the pipeline hold
pix_tick  out  1  one-clk pixel enable
pixel_x  out  COORD_W  current horizontal count
pixel_y  out  COORD_W  current vertical count
hsync  out  1  horizontal sync, delayed by LAT ticks, polarity HS_POL
vsync  out  1  vertical sync, delayed by LAT ticks, polarity VS_POL
video_on  out  1  active region, delayed by LAT ticks
line_start  out  1  one-clk pulse after h wraps to 0
frame_start  out  1  one-clk pulse after h and v both wrap to 0
frame_count  out  16  frames completed, wraps 0xFFFF -> 0

Behaviour:
- Derived totals: H_TOTAL = H_DISP+H_FP+H_SYNC+H_BP (default 800); V_TOTAL = V_DISP+V_FP+V_SYNC+V_BP (default 525).
- Reset (reset = 0, asynchronous) values:
  - div, h and v counters = 0;
  - pipeline stages = inactive;
  - hsync = ~HS_POL, vsync = ~VS_POL;
  - video_on, pix_tick, line_start, frame_start = 0; frame_count = 0.
- Reset asserted mid-frame forces these values immediately.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while en = 1.
  - pix_tick = en && (div_cnt == CLK_DIV-1), so with CLK_DIV = 1, pix_tick = en.
  - After reset release with en = 1, the first pix_tick is in the CLK_DIV-th clk cycle.
- Horizontal counter:
  - h advances on pix_tick.
  - h_end = (h == H_TOTAL-1); on pix_tick && h_end, h goes to 0.
- Vertical counter:
  - v advances on pix_tick && h_end.
  - At v == V_TOTAL-1 it wraps to 0 on the same edge that h wraps.
- pixel_x = h and pixel_y = v, straight from the registers with no delay.
- Decode of the current (h, v):
  - hs_act = H_DISP+H_FP <= h <= H_DISP+H_FP+H_SYNC-1;
  - vs_act = V_DISP+V_FP <= v <= V_DISP+V_FP+V_SYNC-1;
  - vid = (h < H_DISP) && (v < V_DISP).
- Pipeline:
  - LAT stages, each 3 bits wide; all stages shift only on pix_tick.
  - Stage 0 loads the decode of (h, v) before the increment.
  - Outputs come from stage LAT-1, so the strobes describe the position LAT ticks earlier than pixel_x/pixel_y.
  - hsync = hs_act ? HS_POL : ~HS_POL; vsync likewise with VS_POL; video_on = vid.
  - All outputs are registered (glitch-free).
- line_start: registered. It is 1 for exactly one clk, in the cycle after the pix_tick edge where h_end was true.
- frame_start:
  - Same timing as line_start, additionally requiring v == V_TOTAL-1.
  - frame_count increments on that same edge.
  - When frame_start fires, line_start fires in the same cycle.
- en deasserted:
  - div_cnt, h, v, the pipeline and frame_count all hold.
  - pix_tick, line_start and frame_start stay 0.
  - On re-enable, the divider resumes from its held value; there is no phase reset.
- Width: h, v and all compares are COORD_W bits unsigned; frame_count is 16 bits modulo.

Test Plan:
- Defaults, en = 1 after reset release → pix_tick high in clk cycles 4, 8, 12…; pixel_x reaches 799 and wraps to 0 after 800 ticks (3200 clks); line_start pulses once per 3200 clks.
- Defaults, LAT = 1 → hsync is low for exactly 96 ticks. It goes low on the tick edge at which pixel_x becomes 657, one tick after h = 656 was decoded. video_on falls when pixel_x becomes 641.
- Defaults, full frame → vsync is low for 2 lines (decoded v = 490, 491). frame_start occurs once per 420000 ticks, and frame_count = 1 after the first wrap; force frame_count to 0xFFFF and confirm the next frame wraps it to 0.
- HS_POL = 1, VS_POL = 1, CLK_DIV = 1, LAT = 3 → pix_tick is continuously high. The sync pulses are active-high with the same widths. The strobes lag pixel_x by 3 clks; check video_on falls when pixel_x becomes 643.
- en dropped for 50 clks at pixel_x = 300 → pixel_x, pixel_y, the strobes and frame_count are frozen, and pix_tick, line_start and frame_start stay 0. On resume the count continues from 300.
- reset pulsed low mid-frame at (400, 200) → all outputs take their reset values asynchronously within the same cycle. After release, the count restarts at (0, 0) with hsync and vsync inactive.
